// File: rtl/usb_prot_ctrl_if.sv
// Signal bundle between the USB protocol controller and its environment
// (packet decoder, transmitter, host-side queue and shared buffer).
// The master side drives the decoded bus events and host requests.
// The slave side is the controller, which answers with transmitter
// control and status.
interface usb_prot_ctrl_if;
  logic       rx_packet_valid;
  logic [2:0] rx_pid;
  logic       rx_error;
  logic       tx_done;
  logic       host_tx_req;
  logic [2:0] host_tx_pid;
  logic [6:0] buffer_occupancy;

  logic       tx_start;
  logic [2:0] tx_pid;
  logic       d_mode;
  logic       rx_data_ready;
  logic       clear_buffer;
  logic       rx_err_flag;
  logic       timeout;

  modport master (
    output rx_packet_valid, rx_pid, rx_error, tx_done,
           host_tx_req, host_tx_pid, buffer_occupancy,
    input  tx_start, tx_pid, d_mode, rx_data_ready,
           clear_buffer, rx_err_flag, timeout
  );

  modport slave (
    input  rx_packet_valid, rx_pid, rx_error, tx_done,
           host_tx_req, host_tx_pid, buffer_occupancy,
    output tx_start, tx_pid, d_mode, rx_data_ready,
           clear_buffer, rx_err_flag, timeout
  );
endinterface

// File: rtl/usb_prot_ctrl.sv
// USB device-side protocol controller.
// It sequences the token, data and handshake phases of a transaction.
// It arbitrates ownership of the shared buffer between receiver and transmitter.
// A peer that never answers is cut off by a saturating response timer.
module usb_prot_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned BUF_DEPTH   = 64
) (
  input  logic           clk,
  input  logic           rst,
  usb_prot_ctrl_if.slave bus
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RX_EXPECT = 3'd1;
  localparam logic [2:0] ST_TX_HS     = 3'd2;
  localparam logic [2:0] ST_TX_DATA   = 3'd3;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd4;

  localparam logic [2:0] PID_OUT   = 3'd1;
  localparam logic [2:0] PID_IN    = 3'd2;
  localparam logic [2:0] PID_DATA0 = 3'd3;
  localparam logic [2:0] PID_DATA1 = 3'd4;
  localparam logic [2:0] PID_ACK   = 3'd5;
  localparam logic [2:0] PID_NAK   = 3'd6;
  localparam logic [2:0] PID_STALL = 3'd7;

  // The timer is 8 bits wide, so a timeout above 255 behaves like 255.
  localparam logic [7:0] TIMEOUT_VAL = (TIMEOUT_CYC > 255) ? 8'hFF : 8'(TIMEOUT_CYC);

  // Occupancy never exceeds BUF_DEPTH, so only the bits that can count up to it
  // take part in the empty test.
  localparam int OCC_W_RAW = $clog2(BUF_DEPTH + 1);
  localparam int OCC_W     = (OCC_W_RAW > 7) ? 7 : ((OCC_W_RAW < 1) ? 1 : OCC_W_RAW);

  logic [2:0] state;
  logic [7:0] timer;
  logic       tx_pending;
  logic [2:0] pend_pid;

  logic       tx_start_q;
  logic [2:0] tx_pid_q;
  logic       rx_data_ready_q;
  logic       clear_buffer_q;
  logic       rx_err_flag_q;
  logic       timeout_q;

  logic       pkt_ok;
  logic       host_req_ok;
  logic       buf_empty;
  logic [7:0] timer_next;
  logic       timer_expire;

  // A receiver error in the same cycle outranks the packet it arrived with.
  assign pkt_ok      = bus.rx_packet_valid && !bus.rx_error;
  assign host_req_ok = bus.host_tx_req &&
                       ((bus.host_tx_pid == PID_DATA0) || (bus.host_tx_pid == PID_DATA1));
  assign buf_empty   = (bus.buffer_occupancy[OCC_W-1:0] == '0);
  // The timer saturates rather than wraps, so a stalled expiry cannot restart the count.
  assign timer_next   = (timer == 8'hFF) ? timer : timer + 8'd1;
  assign timer_expire = (timer_next >= TIMEOUT_VAL);

  // Transaction state machine, response timer, pending-data bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      timer           <= '0;
      tx_pending      <= 1'b0;
      pend_pid        <= '0;
      tx_start_q      <= 1'b0;
      tx_pid_q        <= '0;
      rx_data_ready_q <= 1'b0;
      clear_buffer_q  <= 1'b0;
      rx_err_flag_q   <= 1'b0;
      timeout_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults followed by conditional overrides; the last
      // assignment in program order wins, which sets priority without a latch.
      tx_start_q     <= 1'b0;
      clear_buffer_q <= 1'b0;
      timeout_q      <= 1'b0;

      if (pkt_ok)
        rx_err_flag_q <= 1'b0;

      // The state is IDLE here, so the receiver does not own the buffer.
      if ((state == ST_IDLE) && buf_empty)
        rx_data_ready_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (pkt_ok) begin
            if (bus.rx_pid == PID_OUT) begin
              state <= ST_RX_EXPECT;
              timer <= '0;
            end else if (bus.rx_pid == PID_IN) begin
              tx_start_q <= 1'b1;
              if (tx_pending) begin
                state    <= ST_TX_DATA;
                tx_pid_q <= pend_pid;
              end else begin
                state    <= ST_TX_HS;
                tx_pid_q <= PID_NAK;
              end
            end
          end
        end

        ST_RX_EXPECT: begin
          if (bus.rx_error) begin
            clear_buffer_q <= 1'b1;
            rx_err_flag_q  <= 1'b1;
            state          <= ST_IDLE;
          end else if (bus.rx_packet_valid) begin
            if ((bus.rx_pid == PID_DATA0) || (bus.rx_pid == PID_DATA1)) begin
              rx_data_ready_q <= 1'b1;
              tx_start_q      <= 1'b1;
              tx_pid_q        <= PID_ACK;
              state           <= ST_TX_HS;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            timer <= timer_next;
            if (timer_expire) begin
              timeout_q <= 1'b1;
              state     <= ST_IDLE;
            end
          end
        end

        ST_TX_HS: begin
          if (bus.tx_done)
            state <= ST_IDLE;
        end

        ST_TX_DATA: begin
          if (bus.tx_done) begin
            state <= ST_WAIT_ACK;
            timer <= '0;
          end
        end

        ST_WAIT_ACK: begin
          if (bus.rx_error) begin
            rx_err_flag_q <= 1'b1;
            state         <= ST_IDLE;
          end else if (bus.rx_packet_valid && (bus.rx_pid == PID_ACK)) begin
            clear_buffer_q <= 1'b1;
            tx_pending     <= 1'b0;
            state          <= ST_IDLE;
          end else if (bus.rx_packet_valid &&
                       ((bus.rx_pid == PID_NAK) || (bus.rx_pid == PID_STALL))) begin
            state <= ST_IDLE;
          end else begin
            timer <= timer_next;
            if (timer_expire) begin
              timeout_q <= 1'b1;
              state     <= ST_IDLE;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase

      // A fresh host request in the same cycle as an ACK keeps the new data pending.
      if (host_req_ok) begin
        tx_pending <= 1'b1;
        pend_pid   <= bus.host_tx_pid;
      end
    end
  end

  assign bus.tx_start      = tx_start_q;
  assign bus.tx_pid        = tx_pid_q;
  assign bus.d_mode        = (state == ST_TX_HS) || (state == ST_TX_DATA);
  assign bus.rx_data_ready = rx_data_ready_q;
  assign bus.clear_buffer  = clear_buffer_q;
  assign bus.rx_err_flag   = rx_err_flag_q;
  assign bus.timeout       = timeout_q;

endmodule

// File: tb/tb_usb_prot_ctrl.sv
// Directed bench for usb_prot_ctrl.
// Inputs change 1 time unit after a rising edge, and outputs are read at the same point.
module tb_usb_prot_ctrl;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  usb_prot_ctrl_if bus();

  usb_prot_ctrl #(.TIMEOUT_CYC(255), .BUF_DEPTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [2:0] pid);
    bus.rx_packet_valid = 1'b1;
    bus.rx_pid          = pid;
    tick();
    bus.rx_packet_valid = 1'b0;
    bus.rx_pid          = 3'd0;
  endtask

  task automatic host_req(input logic [2:0] pid);
    bus.host_tx_req = 1'b1;
    bus.host_tx_pid = pid;
    tick();
    bus.host_tx_req = 1'b0;
    bus.host_tx_pid = 3'd0;
  endtask

  task automatic pulse_tx_done();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  task automatic pulse_rx_error();
    bus.rx_error = 1'b1;
    tick();
    bus.rx_error = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.tx_start, bus.tx_pid, bus.d_mode, bus.rx_data_ready,
         bus.clear_buffer, bus.rx_err_flag, bus.timeout} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b",
               {bus.tx_start, bus.tx_pid, bus.d_mode, bus.rx_data_ready,
                bus.clear_buffer, bus.rx_err_flag, bus.timeout}, 9'b0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.tx_start, bus.clear_buffer} !== 2'b00) begin
      errors++;
      $display("FAIL reset_exit_pulses: got %b expected 00", {bus.tx_start, bus.clear_buffer});
    end
  endtask

  task automatic test_out_data();
    bus.buffer_occupancy = 7'd10;
    send_pkt(3'd1);
    checks++;
    if ({bus.tx_start, bus.d_mode} !== 2'b00) begin
      errors++;
      $display("FAIL out_token_quiet: got %b expected 00", {bus.tx_start, bus.d_mode});
    end
    send_pkt(3'd4);
    checks++;
    if ({bus.tx_start, bus.tx_pid, bus.d_mode, bus.rx_data_ready} !== {1'b1, 3'd5, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL data1_ack_start: got %b expected %b",
               {bus.tx_start, bus.tx_pid, bus.d_mode, bus.rx_data_ready}, {1'b1, 3'd5, 1'b1, 1'b1});
    end
    tick();
    checks++;
    if ({bus.tx_start, bus.tx_pid, bus.d_mode} !== {1'b0, 3'd5, 1'b1}) begin
      errors++;
      $display("FAIL ack_hold: got %b expected %b", {bus.tx_start, bus.tx_pid, bus.d_mode}, {1'b0, 3'd5, 1'b1});
    end
    pulse_tx_done();
    tick();
    checks++;
    if ({bus.d_mode, bus.rx_data_ready} !== 2'b01) begin
      errors++;
      $display("FAIL ack_done_idle: got %b expected 01", {bus.d_mode, bus.rx_data_ready});
    end
    bus.buffer_occupancy = 7'd0;
    tick();
    checks++;
    if (bus.rx_data_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_clear_idle_empty: got %b expected 0", bus.rx_data_ready);
    end
  endtask

  task automatic test_ready_hold();
    bus.buffer_occupancy = 7'd0;
    send_pkt(3'd1);
    send_pkt(3'd3);
    tick();
    checks++;
    if ({bus.rx_data_ready, bus.d_mode} !== 2'b11) begin
      errors++;
      $display("FAIL ready_hold_tx_hs: got %b expected 11", {bus.rx_data_ready, bus.d_mode});
    end
    pulse_tx_done();
    checks++;
    if (bus.rx_data_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_hold_last_tx_cycle: got %b expected 1", bus.rx_data_ready);
    end
    tick();
    checks++;
    if (bus.rx_data_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_clear_after_tx: got %b expected 0", bus.rx_data_ready);
    end
  endtask

  task automatic test_in_nak();
    send_pkt(3'd2);
    checks++;
    if ({bus.tx_start, bus.tx_pid, bus.d_mode} !== {1'b1, 3'd6, 1'b1}) begin
      errors++;
      $display("FAIL in_nak: got %b expected %b", {bus.tx_start, bus.tx_pid, bus.d_mode}, {1'b1, 3'd6, 1'b1});
    end
    pulse_tx_done();
    checks++;
    if (bus.d_mode !== 1'b0) begin
      errors++;
      $display("FAIL in_nak_done: got %b expected 0", bus.d_mode);
    end
  endtask

  task automatic test_in_data_ack();
    host_req(3'd3);
    checks++;
    if (dut.tx_pending !== 1'b1) begin
      errors++;
      $display("FAIL host_req_pending: got %b expected 1", dut.tx_pending);
    end
    send_pkt(3'd2);
    checks++;
    if ({bus.tx_start, bus.tx_pid, bus.d_mode} !== {1'b1, 3'd3, 1'b1}) begin
      errors++;
      $display("FAIL in_data0: got %b expected %b", {bus.tx_start, bus.tx_pid, bus.d_mode}, {1'b1, 3'd3, 1'b1});
    end
    pulse_tx_done();
    send_pkt(3'd5);
    checks++;
    if ({bus.clear_buffer, dut.tx_pending, bus.d_mode} !== 3'b100) begin
      errors++;
      $display("FAIL ack_clear: got %b expected 100", {bus.clear_buffer, dut.tx_pending, bus.d_mode});
    end
    tick();
    checks++;
    if (bus.clear_buffer !== 1'b0) begin
      errors++;
      $display("FAIL ack_clear_pulse_width: got %b expected 0", bus.clear_buffer);
    end
  endtask

  task automatic test_bad_host_pid();
    host_req(3'd5);
    send_pkt(3'd2);
    checks++;
    if ({dut.tx_pending, bus.tx_pid} !== {1'b0, 3'd6}) begin
      errors++;
      $display("FAIL bad_host_pid: got %b expected %b", {dut.tx_pending, bus.tx_pid}, {1'b0, 3'd6});
    end
    pulse_tx_done();
  endtask

  task automatic test_pending_wait_ack();
    int n;
    host_req(3'd3);
    host_req(3'd4);
    send_pkt(3'd2);
    checks++;
    if ({bus.tx_start, bus.tx_pid} !== {1'b1, 3'd4}) begin
      errors++;
      $display("FAIL pend_overwrite: got %b expected %b", {bus.tx_start, bus.tx_pid}, {1'b1, 3'd4});
    end
    pulse_tx_done();
    pulse_rx_error();
    checks++;
    if ({bus.rx_err_flag, dut.tx_pending, bus.clear_buffer} !== 3'b110) begin
      errors++;
      $display("FAIL wait_ack_rx_error: got %b expected 110", {bus.rx_err_flag, dut.tx_pending, bus.clear_buffer});
    end
    send_pkt(3'd2);
    checks++;
    if ({bus.tx_start, bus.tx_pid, bus.rx_err_flag} !== {1'b1, 3'd4, 1'b0}) begin
      errors++;
      $display("FAIL retry_after_error: got %b expected %b", {bus.tx_start, bus.tx_pid, bus.rx_err_flag}, {1'b1, 3'd4, 1'b0});
    end
    pulse_tx_done();
    send_pkt(3'd6);
    checks++;
    if ({dut.tx_pending, bus.clear_buffer} !== 2'b10) begin
      errors++;
      $display("FAIL nak_keeps_pending: got %b expected 10", {dut.tx_pending, bus.clear_buffer});
    end
    send_pkt(3'd2);
    pulse_tx_done();
    n = 0;
    while (bus.timeout !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n != 255) begin
      errors++;
      $display("FAIL wait_ack_timeout_cycles: got %0d expected 255", n);
    end
    checks++;
    if ({dut.tx_pending, bus.d_mode} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_keeps_pending: got %b expected 10", {dut.tx_pending, bus.d_mode});
    end
    tick();
    checks++;
    if (bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse_width: got %b expected 0", bus.timeout);
    end
    send_pkt(3'd2);
    checks++;
    if ({bus.tx_start, bus.tx_pid} !== {1'b1, 3'd4}) begin
      errors++;
      $display("FAIL resend_after_timeout: got %b expected %b", {bus.tx_start, bus.tx_pid}, {1'b1, 3'd4});
    end
    pulse_tx_done();
    send_pkt(3'd5);
    checks++;
    if ({bus.clear_buffer, dut.tx_pending} !== 2'b10) begin
      errors++;
      $display("FAIL final_ack: got %b expected 10", {bus.clear_buffer, dut.tx_pending});
    end
  endtask

  task automatic test_rx_error_priority();
    int n;
    bus.buffer_occupancy = 7'd5;
    send_pkt(3'd1);
    bus.rx_error        = 1'b1;
    bus.rx_packet_valid = 1'b1;
    bus.rx_pid          = 3'd3;
    tick();
    bus.rx_error        = 1'b0;
    bus.rx_packet_valid = 1'b0;
    bus.rx_pid          = 3'd0;
    checks++;
    if ({bus.clear_buffer, bus.rx_err_flag, bus.rx_data_ready, bus.tx_start, bus.d_mode} !== 5'b11000) begin
      errors++;
      $display("FAIL rx_error_priority: got %b expected 11000",
               {bus.clear_buffer, bus.rx_err_flag, bus.rx_data_ready, bus.tx_start, bus.d_mode});
    end
    tick();
    checks++;
    if ({bus.clear_buffer, bus.rx_err_flag} !== 2'b01) begin
      errors++;
      $display("FAIL err_flag_sticky: got %b expected 01", {bus.clear_buffer, bus.rx_err_flag});
    end
    send_pkt(3'd1);
    checks++;
    if (bus.rx_err_flag !== 1'b0) begin
      errors++;
      $display("FAIL err_flag_clear: got %b expected 0", bus.rx_err_flag);
    end
    n = 0;
    while (bus.timeout !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n != 255) begin
      errors++;
      $display("FAIL rx_expect_timeout_cycles: got %0d expected 255", n);
    end
  endtask

  task automatic test_reset_mid_tx();
    host_req(3'd3);
    send_pkt(3'd2);
    checks++;
    if (bus.d_mode !== 1'b1) begin
      errors++;
      $display("FAIL mid_tx_setup: got %b expected 1", bus.d_mode);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.d_mode, dut.tx_pending, bus.tx_start, bus.tx_pid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_tx: got %b expected 000000", {bus.d_mode, dut.tx_pending, bus.tx_start, bus.tx_pid});
    end
    tick();
    checks++;
    if ({bus.tx_start, bus.clear_buffer, bus.d_mode} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_tx_exit: got %b expected 000", {bus.tx_start, bus.clear_buffer, bus.d_mode});
    end
    send_pkt(3'd2);
    checks++;
    if ({bus.tx_start, bus.tx_pid} !== {1'b1, 3'd6}) begin
      errors++;
      $display("FAIL in_after_reset: got %b expected %b", {bus.tx_start, bus.tx_pid}, {1'b1, 3'd6});
    end
    pulse_tx_done();
  endtask

  initial begin
    rst                  = 1'b1;
    bus.rx_packet_valid  = 1'b0;
    bus.rx_pid           = 3'd0;
    bus.rx_error         = 1'b0;
    bus.tx_done          = 1'b0;
    bus.host_tx_req      = 1'b0;
    bus.host_tx_pid      = 3'd0;
    bus.buffer_occupancy = 7'd0;

    test_reset();
    test_out_data();
    test_ready_hold();
    test_in_nak();
    test_in_data_ack();
    test_bad_host_pid();
    test_pending_wait_ack();
    test_rx_error_priority();
    test_reset_mid_tx();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/usb_prot_ctrl.md
USB_PROT_CTRL -- requirements
Module: usb_prot_ctrl

Interface
REQ-001 SHALL provide params: TIMEOUT_CYC, default 255, peer-response timeout in cycles; BUF_DEPTH, default 64, shared buffer bytes.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx_packet_valid  in  1  one-cycle pulse, decoded PID on rx_pid
- rx_pid  in  3  0 none, 1 OUT, 2 IN, 3 DATA0, 4 DATA1, 5 ACK, 6 NAK, 7 STALL
- rx_error  in  1  one-cycle pulse, receiver framing/CRC error
- tx_done  in  1  one-cycle pulse, transmitter finished packet
- host_tx_req  in  1  one-cycle pulse, host queued TX data
- host_tx_pid  in  3  PID (3/4) for queued data
- buffer_occupancy  in  7  shared buffer bytes, 0..BUF_DEPTH
- tx_start  out  1  one-cycle pulse, start transmitter
- tx_pid  out  3  PID to transmit, valid while tx_start=1
- d_mode  out  1  1 = transmitter owns bus/buffer
- rx_data_ready  out  1  level, received data in buffer
- clear_buffer  out  1  one-cycle pulse, flush shared buffer
- rx_err_flag  out  1  sticky error status
- timeout  out  1  one-cycle pulse, peer response timeout

Function
REQ-003 SHALL implement FSM states IDLE, RX_EXPECT, TX_HS, TX_DATA, WAIT_ACK.
REQ-004 SHALL keep tx_pending/pend_pid: set by host_tx_req (pend_pid=host_tx_pid) in any state, later request overwrites pend_pid; cleared only as REQ-011.
REQ-005 IDLE: rx_pid=OUT -> RX_EXPECT; rx_pid=IN with tx_pending -> TX_DATA, tx_pid=pend_pid; rx_pid=IN without tx_pending -> TX_HS, tx_pid=NAK(6); other PIDs ignored.
REQ-006 RX_EXPECT: rx_pid DATA0/DATA1 -> set rx_data_ready, TX_HS with tx_pid=ACK(5); any other PID -> IDLE; rx_error -> clear_buffer pulse, set rx_err_flag, IDLE.
REQ-007 tx_start SHALL pulse exactly on the first cycle in TX_HS or TX_DATA (registered, 1 cycle after the transition cycle); tx_pid SHALL hold its value through the state.
REQ-008 d_mode SHALL be 1 in TX_HS and TX_DATA, else 0.
REQ-009 TX_HS: tx_done -> IDLE. TX_DATA: tx_done -> WAIT_ACK. No timeout in TX states.
REQ-010 Timer: 8-bit counter cleared on entry to RX_EXPECT/WAIT_ACK, increments each cycle there; reaching TIMEOUT_CYC -> timeout pulse, IDLE; saturates, never wraps.
REQ-011 WAIT_ACK: ACK -> clear_buffer pulse, clear tx_pending, IDLE; NAK or STALL -> IDLE, tx_pending kept; rx_error -> set rx_err_flag, IDLE, tx_pending kept.
REQ-012 Same-cycle priority: rst > rx_error > rx_packet_valid > timer expiry.
REQ-013 rx_data_ready SHALL clear when buffer_occupancy==0 while d_mode=0 and state is IDLE; it SHALL NOT clear in RX_EXPECT or TX_HS.
REQ-014 rx_err_flag SHALL clear on the next rx_packet_valid with no simultaneous rx_error.
REQ-015 host_tx_req with host_tx_pid not 3/4 SHALL be ignored.
REQ-016 rx_pid SHALL be sampled only when rx_packet_valid=1.

Reset
REQ-017 rst=1 at clock edge -> state IDLE, tx_pending=0, timer=0, all outputs 0 next cycle, including mid-TX; no tx_start/clear_buffer pulse on reset exit.

Verification
REQ-018 OUT then DATA1 -> rx_data_ready=1, tx_start pulse with tx_pid=5, d_mode=1 until tx_done, then IDLE.
REQ-019 IN, no host data -> tx_start with tx_pid=6; host_tx_req(pid 3) then IN -> tx_pid=3, ACK -> clear_buffer pulse, tx_pending=0.
REQ-020 TX_DATA, tx_done, no response -> timeout pulse exactly TIMEOUT_CYC cycles after WAIT_ACK entry, IDLE, tx_pending=1.
REQ-021 RX_EXPECT with rx_error and rx_packet_valid(DATA0) same cycle -> error path: clear_buffer=1, rx_err_flag=1, rx_data_ready=0.
REQ-022 rst asserted in TX_DATA -> next cycle d_mode=0, tx_pending=0, IDLE; later IN answered with NAK.
